wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Consumer end of the unit writeback interface (done/rd/id from the unit, ack back to it).
- Collects results from NUM_UNITS execution units (mul, div, alu, ...) and grants one per cycle using round-robin arbitration.
- Acks the granted unit and holds the winner in a registered commit stage that drives the register-file/ID-retire port.
- Commit stage has a valid/ready handshake toward retire.

Parameters:
- NUM_UNITS, 4, number of writeback requesters (range 2..8).
- DATA_WIDTH, 32, width of rd result.
- ID_WIDTH, 3, width of instruction id (matches id_t).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low (0 = reset).
- unit_done  in  NUM_UNITS  per-unit result valid (unit holds it until acked).
- unit_rd  in  NUM_UNITS x DATA_WIDTH  per-unit result data.
- unit_id  in  NUM_UNITS x ID_WIDTH  per-unit instruction id.
- unit_ack  out  NUM_UNITS  one-hot (or zero) grant; the unit advances its pipeline on it.
- commit_valid  out  1  registered result present.
- commit_ready  in  1  retire accepts commit this cycle.
- commit_data  out  DATA_WIDTH  registered result.
- commit_id  out  ID_WIDTH  registered id.
- commit_unit  out  clog2(NUM_UNITS)  index of the unit that produced the commit.

Behaviour:
- Reset (rst==0 at posedge):
  - commit_valid=0, commit_data=0, commit_id=0, commit_unit=0.
  - Priority pointer = 0.
  - Any held commit is discarded.
  - unit_ack is combinational; it is 0 while rst==0.
- advance = ~commit_valid | commit_ready.
- Grant is combinational:
  - Search from pointer upward, wrapping modulo NUM_UNITS.
  - The first unit with unit_done=1 wins.
  - unit_ack[winner] = advance; all other acks are 0.
  - No done asserted → all acks 0.
- At posedge, if advance:
  - commit_valid <= any done.
  - If a unit won: commit_data, commit_id and commit_unit <= the winner's fields.
  - If nothing won: the payload holds its old value.
- Pointer update on a granted ack: pointer <= winner+1 mod NUM_UNITS. Otherwise the pointer holds.
- If advance=0: commit registers hold, all acks are 0, and requests stay pending.
- Latency: done seen at cycle N with advance → commit_valid at N+1.
- Throughput: 1 result/cycle when commit_ready is held high.
- Simultaneous drain and refill (commit_valid=1, commit_ready=1, new done) is loaded in the same edge with no bubble.
- Fairness: a continuously requesting unit is granted within NUM_UNITS grants.
- unit_ack never depends on commit_data/commit_id. It is a function of unit_done, pointer, commit_valid and commit_ready only.
- Pointer wrap-around: winner = NUM_UNITS-1 → pointer 0.

Optional Feature:
- Macro: WB_ARB_CONFLICT_COUNT_EN.
- Defined:
  - Adds output port conflict_count (32 bits).
  - Counts cycles where advance=1 and two or more unit_done are asserted.
  - Reset 0; saturates at 0xFFFFFFFF.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (cva5_types):
  - wb_commit_packet_t {data, id, unit}.
  - Constant WB_UNIT_IDX_W = clog2(NUM_UNITS).
- One sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: request vector, advance.
  - Outputs: one-hot grant, winner index.
  - Owns the pointer register.
  - Reused by the future load-store request arbiter.

Test Plan:
- Single requester: unit 2 done, rd=0xDEADBEEF, id=5, commit_ready=1 → unit_ack=0b0100 same cycle; next cycle commit_valid=1, commit_data=0xDEADBEEF, commit_id=5, commit_unit=2.
- Contention: units 0,1,3 held done continuously, pointer=0, commit_ready=1 → grants 0,1,3,0,1,3 on consecutive cycles, no bubbles.
- Backpressure: commit_valid=1, commit_ready=0 for 3 cycles with unit 1 done → unit_ack=0 for those cycles, commit registers unchanged; on commit_ready=1 unit 1 is acked and loaded next cycle.
- Wrap: pointer=3 (NUM_UNITS=4), units 0 and 3 done → unit 3 wins, pointer becomes 0, then unit 0 wins.
- Reset mid-operation: commit_valid=1, units requesting, rst=0 for one edge → commit_valid=0, pointer=0, no ack during reset; unit 0 is granted first after release.
- WB_ARB_CONFLICT_COUNT_EN: 10 cycles with two units done and commit_ready=1 → conflict_count=10; 5 single-request cycles leave it at 10.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types: default unit/data/id widths, commit packet layout,
// and a helper that sizes unit-index fields (at least 1 bit).
// Imported by wb_arbiter and rr_arbiter; no logic, no latency, no flow control.
package wb_arbiter_pkg;

  localparam int WB_NUM_UNITS = 4;
  localparam int WB_DATA_W    = 32;
  localparam int WB_ID_W      = 3;

  // Width of an index into n requesters; never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int WB_UNIT_IDX_W = idx_width(WB_NUM_UNITS);

  typedef logic [WB_ID_W-1:0] id_t;

  typedef struct packed {
    logic [WB_DATA_W-1:0]     data;
    id_t                      id;
    logic [WB_UNIT_IDX_W-1:0] unit;
  } wb_commit_packet_t;

endpackage

// File: rtl/wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or above the priority
// pointer (wrapping), pointer moves past the winner only when a grant issues.
// Latency: grant is combinational. Backpressure: advance=0 suppresses all
// grants and freezes the pointer, so requests stay pending.
// Ports:
//   clk, rst (sync, active-low) | req[N]: request vector | advance: consumer
//   can take a result | grant[N]: one-hot grant | winner: index of first
//   requester | found: any request present (independent of advance).
module rr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = idx_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  logic [IDX_W-1:0] ptr_q, ptr_d;

  // Scan N slots starting at the pointer; cand wraps back to 0 past N-1.
  always_comb begin
    int cand;
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N) cand = cand - N;
      if (!found && req[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  // No grant while held in reset so units never advance on a discarded result.
  always_comb begin
    grant = '0;
    if (found && advance && rst) grant[winner] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found && advance) begin
      ptr_d = (winner == IDX_W'(N - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin grant among NUM_UNITS results into a
// registered commit stage (valid/ready toward retire).
// Latency: done at cycle N -> commit_valid at N+1; 1 result/cycle, no bubble
// on simultaneous drain/refill. Backpressure: commit_ready=0 with a held
// commit stalls all acks and holds the commit registers.
// Ports:
//   clk, rst (sync, active-low) | unit_done/unit_rd/unit_id: per-unit results
//   held until acked | unit_ack: one-hot grant | commit_valid/ready/data/id/
//   unit: registered winner toward retire.
// Optional: define WB_ARB_CONFLICT_COUNT_EN to add conflict_count, a
// saturating count of advancing cycles with two or more units done.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_UNITS  = WB_NUM_UNITS,
  parameter int DATA_WIDTH = WB_DATA_W,
  parameter int ID_WIDTH   = WB_ID_W,
  localparam int UNIT_IDX_W = idx_width(NUM_UNITS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_UNITS-1:0]                 unit_done,
  input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] unit_rd,
  input  logic [NUM_UNITS-1:0][ID_WIDTH-1:0]   unit_id,
  output logic [NUM_UNITS-1:0]                 unit_ack,
  output logic                                 commit_valid,
  input  logic                                 commit_ready,
  output logic [DATA_WIDTH-1:0]                commit_data,
  output logic [ID_WIDTH-1:0]                  commit_id,
  output logic [UNIT_IDX_W-1:0]                commit_unit
`ifdef WB_ARB_CONFLICT_COUNT_EN
  ,
  output logic [31:0]                          conflict_count
`endif
);

  // Commit payload sized from this instance's parameters.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
    logic [UNIT_IDX_W-1:0] unit;
  } commit_pkt_t;

  logic                  commit_valid_q, commit_valid_d;
  commit_pkt_t           commit_q, commit_d;
  logic                  advance;
  logic [UNIT_IDX_W-1:0] winner;
  logic                  found;

  // The stage can load whenever it is empty or being drained this cycle.
  assign advance = ~commit_valid_q | commit_ready;

  rr_arbiter #(
    .N (NUM_UNITS)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (unit_done),
    .advance (advance),
    .grant   (unit_ack),
    .winner  (winner),
    .found   (found)
  );

  // Payload keeps its old value when the stage advances with no winner.
  always_comb begin
    commit_valid_d = commit_valid_q;
    commit_d       = commit_q;
    if (advance) begin
      commit_valid_d = found;
      if (found) begin
        commit_d.data = unit_rd[winner];
        commit_d.id   = unit_id[winner];
        commit_d.unit = winner;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      commit_valid_q <= 1'b0;
      commit_q       <= '0;
    end else begin
      commit_valid_q <= commit_valid_d;
      commit_q       <= commit_d;
    end
  end

  assign commit_valid = commit_valid_q;
  assign commit_data  = commit_q.data;
  assign commit_id    = commit_q.id;
  assign commit_unit  = commit_q.unit;

`ifdef WB_ARB_CONFLICT_COUNT_EN
  logic [31:0] conflict_q, conflict_d;
  logic        multi_req;

  // Clearing the lowest set bit leaves something only if 2+ bits were set.
  assign multi_req = (unit_done & (unit_done - 1'b1)) != '0;

  always_comb begin
    conflict_d = conflict_q;
    if (advance && multi_req && (conflict_q != 32'hFFFF_FFFF)) begin
      conflict_d = conflict_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) conflict_q <= '0;
    else      conflict_q <= conflict_d;
  end

  assign conflict_count = conflict_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all compared against a behavioural model of the writeback rules.
// Inputs change 1ns after posedge; acks are checked at negedge, commit outputs
// 1ns after the following posedge.
module tb_wb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 3;
  localparam int UW = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N-1:0]          unit_done;
  logic [N-1:0][DW-1:0]  unit_rd;
  logic [N-1:0][IW-1:0]  unit_id;
  logic [N-1:0]          unit_ack;
  logic                  commit_valid;
  logic                  commit_ready;
  logic [DW-1:0]         commit_data;
  logic [IW-1:0]         commit_id;
  logic [UW-1:0]         commit_unit;
`ifdef WB_ARB_CONFLICT_COUNT_EN
  logic [31:0]           conflict_count;
`endif

  wb_arbiter #(
    .NUM_UNITS  (N),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .unit_done    (unit_done),
    .unit_rd      (unit_rd),
    .unit_id      (unit_id),
    .unit_ack     (unit_ack),
    .commit_valid (commit_valid),
    .commit_ready (commit_ready),
    .commit_data  (commit_data),
    .commit_id    (commit_id),
    .commit_unit  (commit_unit)
`ifdef WB_ARB_CONFLICT_COUNT_EN
    ,
    .conflict_count (conflict_count)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: priority pointer and the contents of the commit stage.
  int            m_ptr   = 0;
  bit            m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic [IW-1:0] m_id    = '0;
  int            m_unit  = 0;
  longint        m_conf  = 0;
  logic [N-1:0]  exp_ack;
  logic [N-1:0]  obs_ack;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Winner = done unit with the smallest circular distance from the pointer.
  function automatic int model_winner(input logic [N-1:0] done, input int ptr);
    int best, bestd, d;
    best  = -1;
    bestd = N;
    for (int u = 0; u < N; u++) begin
      d = (u - ptr + N) % N;
      if (done[u] && d < bestd) begin
        best  = u;
        bestd = d;
      end
    end
    return best;
  endfunction

  // One clock: check acks against the model, clock, update the model, check
  // the commit stage.
  task automatic cycle();
    int w, cnt;
    bit adv;
    @(negedge clk);
    adv = !m_valid || commit_ready;
    w   = model_winner(unit_done, m_ptr);
    exp_ack = '0;
    if (rst && adv && w >= 0) exp_ack[w] = 1'b1;
    obs_ack = unit_ack;
    chk("ack", {60'd0, unit_ack}, {60'd0, exp_ack});
    cnt = $countones(unit_done);
    if (!rst) begin
      m_ptr = 0; m_valid = 1'b0; m_data = '0; m_id = '0; m_unit = 0; m_conf = 0;
    end else if (adv) begin
      if (cnt >= 2 && m_conf < 64'hFFFF_FFFF) m_conf++;
      m_valid = (w >= 0);
      if (w >= 0) begin
        m_data = unit_rd[w];
        m_id   = unit_id[w];
        m_unit = w;
        m_ptr  = (w + 1) % N;
      end
    end
    @(posedge clk);
    #1;
    chk("commit_valid", {63'd0, commit_valid}, {63'd0, m_valid});
    chk("commit_data", {32'd0, commit_data}, {32'd0, m_data});
    chk("commit_id", {61'd0, commit_id}, {61'd0, m_id});
    chk("commit_unit", {62'd0, commit_unit}, 64'(m_unit));
`ifdef WB_ARB_CONFLICT_COUNT_EN
    chk("conflict_count", {32'd0, conflict_count}, 64'(m_conf));
`endif
  endtask

  initial begin
    logic [DW-1:0] held;
    rst = 1'b0; commit_ready = 1'b1; unit_done = '0;
    for (int u = 0; u < N; u++) begin
      unit_rd[u] = 32'h1000_0000 + DW'(u);
      unit_id[u] = IW'(u);
    end

    // Reset state.
    cycle(); cycle();
    chk("reset_valid", {63'd0, commit_valid}, 64'd0);
    chk("reset_data", {32'd0, commit_data}, 64'd0);
    #1 rst = 1'b1;

    // Single requester: unit 2.
    unit_done = 4'b0100; unit_rd[2] = 32'hDEAD_BEEF; unit_id[2] = 3'd5;
    cycle();
    chk("single_ack", {60'd0, obs_ack}, 64'h4);
    chk("single_valid", {63'd0, commit_valid}, 64'd1);
    chk("single_data", {32'd0, commit_data}, 64'hDEAD_BEEF);
    chk("single_id", {61'd0, commit_id}, 64'd5);
    chk("single_unit", {62'd0, commit_unit}, 64'd2);
    unit_done = '0;
    cycle();
    chk("single_drain", {63'd0, commit_valid}, 64'd0);

    // Wrap: pointer is now 3, units 0 and 3 request.
    unit_done = 4'b1001;
    cycle();
    chk("wrap_first", {62'd0, commit_unit}, 64'd3);
    unit_done[3] = 1'b0;
    cycle();
    chk("wrap_second", {62'd0, commit_unit}, 64'd0);
    unit_done = '0;
    cycle();

    // Contention from pointer 0: units 0,1,3 held continuously.
    rst = 1'b0; cycle(); rst = 1'b1;
    unit_done = 4'b1011;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("contend_valid", {63'd0, commit_valid}, 64'd1);
      chk("contend_unit", {62'd0, commit_unit}, (k % 3 == 2) ? 64'd3 : 64'(k % 3));
    end

    // Backpressure: held commit, retire stalled for 3 cycles.
    held = commit_data;
    unit_done = 4'b0010; unit_rd[1] = 32'hCAFE_0001; unit_id[1] = 3'd6;
    commit_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_ack", {60'd0, obs_ack}, 64'd0);
      chk("bp_hold", {32'd0, commit_data}, {32'd0, held});
    end
    commit_ready = 1'b1;
    cycle();
    chk("bp_release_ack", {60'd0, obs_ack}, 64'h2);
    chk("bp_release_unit", {62'd0, commit_unit}, 64'd1);
    chk("bp_release_data", {32'd0, commit_data}, 64'hCAFE_0001);

    // Reset mid-operation with everyone requesting.
    unit_done = 4'b1111;
    rst = 1'b0;
    cycle();
    chk("midrst_ack", {60'd0, obs_ack}, 64'd0);
    chk("midrst_valid", {63'd0, commit_valid}, 64'd0);
    rst = 1'b1;
    cycle();
    chk("midrst_first", {60'd0, obs_ack}, 64'h1);

`ifdef WB_ARB_CONFLICT_COUNT_EN
    rst = 1'b0; cycle(); rst = 1'b1;
    unit_done = 4'b0011;
    repeat (10) cycle();
    chk("conf_ten", {32'd0, conflict_count}, 64'd10);
    unit_done = 4'b0100;
    repeat (5) cycle();
    chk("conf_single", {32'd0, conflict_count}, 64'd10);
`endif

    // Random traffic: units hold done until acked, then may refill at once.
    unit_done = '0;
    for (int k = 0; k < 400; k++) begin
      for (int u = 0; u < N; u++) begin
        if (obs_ack[u]) unit_done[u] = 1'b0;
        if (!unit_done[u] && $urandom_range(1) == 1) begin
          unit_done[u] = 1'b1;
          unit_rd[u]   = $urandom;
          unit_id[u]   = IW'($urandom_range(7));
        end
      end
      commit_ready = ($urandom_range(3) != 0);
      rst = ($urandom_range(49) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
